// File: rtl/ahb_sram_if.sv
// AHB-Lite bundle between an initiator (master) and one word-addressed SRAM responder (slave).
// The master drives address/control/write data; the slave returns ready, response and read data.
interface ahb_sram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: legal beats complete 1+WAIT_STATES cycles after the address edge.
// Backpressure: hreadyout held low for wait states and for the first cycle of a two-cycle ERROR.
module ahb_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic      hclk,
  input  logic      hreset,
  ahb_sram_if.slave bus
);
  localparam int unsigned AW      = $clog2(4 * DEPTH_WORDS);
  localparam int unsigned WW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic [WW-1:0] lat_word;
  logic [3:0]    lat_be;
  logic          lat_write;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          size_bad, misaligned, out_of_range, illegal;
  logic          can_accept, accept;
  logic [3:0]    be;
  logic          unused_ok;

  assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock};

  // Address-phase decode; an illegal beat is never latched so it cannot reach the SRAM.
  assign offset       = bus.haddr - BASE_ADDR;
  assign size_bad     = bus.hsize > 3'd2;
  assign misaligned   = (bus.hsize == 3'd1 && bus.haddr[0]) ||
                        (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00);
  assign out_of_range = offset >= SPAN;
  assign illegal      = size_bad | misaligned | out_of_range;
  assign can_accept   = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept       = can_accept & bus.hsel & bus.hready & bus.htrans[1];

  always_comb begin
    be = 4'b1111;
    case (bus.hsize)
      3'd0:    be = 4'b0001 << bus.haddr[1:0];
      3'd1:    be = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_word  <= '0;
      lat_be    <= 4'b0000;
      lat_write <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept && !illegal) begin
        lat_word  <= offset[AW-1:2];
        lat_be    <= be;
        lat_write <= bus.hwrite;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = 32'h0;
    case (state)
      ST_WAIT: begin
        bus.hreadyout = 1'b0;
        wait_cnt_nxt  = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        state_nxt     = ST_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all accept the next pipelined address the same way.
        if (state == ST_ERR2) bus.hresp = 1'b1;
        if (state == ST_DATA && !lat_write) bus.hrdata = mem[lat_word];
        state_nxt = ST_IDLE;
        if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_LD != 4'd0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LD;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
    endcase
  end

  // Write commits at the end of its data phase, so a back-to-back read sees the new word.
  always_ff @(posedge hclk) begin
    if (!hreset && state == ST_DATA && lat_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_word][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench: three SRAM slaves (0, 2 and 1 wait states) behind a small data-phase mux,
// driven by a pipelined master with a scoreboard of expected responses.
module tb_ahb_sram_slave;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel_g = 1'b0;
  int          cur_dut = 0;
  int          owner = 3;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = 32'h0;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    int          waits;
    bit          err;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  bit          have_pend = 0;
  logic [31:0] pend_wdata = 32'h0;
  logic [31:0] model [3][1024];

  always #5 hclk = ~hclk;

  ahb_sram_if bus0();
  ahb_sram_if bus1();
  ahb_sram_if bus2();

  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0))
    dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0.slave));
  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0))
    dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1.slave));
  ahb_sram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0))
    dut2 (.hclk(hclk), .hreset(hreset), .bus(bus2.slave));

  assign bus0.hsel = hsel_g && (cur_dut == 0);
  assign bus1.hsel = hsel_g && (cur_dut == 1);
  assign bus2.hsel = hsel_g && (cur_dut == 2);
  assign {bus0.haddr, bus1.haddr, bus2.haddr}   = {3{haddr}};
  assign {bus0.htrans, bus1.htrans, bus2.htrans} = {3{htrans}};
  assign {bus0.hwrite, bus1.hwrite, bus2.hwrite} = {3{hwrite}};
  assign {bus0.hsize, bus1.hsize, bus2.hsize}   = {3{hsize}};
  assign {bus0.hburst, bus1.hburst, bus2.hburst} = {3{hburst}};
  assign {bus0.hprot, bus1.hprot, bus2.hprot}   = {3{4'b0011}};
  assign {bus0.hmastlock, bus1.hmastlock, bus2.hmastlock} = 3'b000;
  assign {bus0.hwdata, bus1.hwdata, bus2.hwdata} = {3{hwdata}};
  assign {bus0.hready, bus1.hready, bus2.hready} = {3{m_hready}};

  // Data-phase owner select; owner 3 is the default slave (always ready, OKAY).
  always @(posedge hclk) begin
    if (hreset) owner <= 3;
    else if (m_hready) owner <= hsel_g ? cur_dut : 3;
  end

  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = 32'h0;
    case (owner)
      0: begin m_hready = bus0.hreadyout; m_hresp = bus0.hresp; m_hrdata = bus0.hrdata; end
      1: begin m_hready = bus1.hreadyout; m_hresp = bus1.hresp; m_hrdata = bus1.hrdata; end
      2: begin m_hready = bus2.hreadyout; m_hresp = bus2.hresp; m_hrdata = bus2.hrdata; end
      default: ;
    endcase
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction

  // Issue one address phase while completing the previous beat's data phase.
  task automatic beat(input int d, input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e, ep;
    bit          bad, rdy, done;
    int          w;
    logic [31:0] word;
    e.chk_data = 0; e.data = 32'h0; e.waits = 0; e.err = 0; e.addr = a;
    if (sel && tr[1]) begin
      bad = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
            (a >= 32'd4096);
      if (bad) begin
        e.waits = 1; e.err = 1;
      end else begin
        e.waits = ws_of(d);
        word = model[d][a[11:2]];
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (sz == 3'd2 || (sz == 3'd1 && i[1] == a[1]) || (sz == 3'd0 && i == int'(a[1:0])))
              word[8*i +: 8] = wd[8*i +: 8];
          model[d][a[11:2]] = word;
        end else begin
          e.chk_data = 1; e.data = word;
        end
      end
    end
    cur_dut = d; hsel_g = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
    hwdata = pend_wdata;
    w = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge hclk);
      rdy = m_hready;
      if (have_pend && sb.size() > 0) begin
        if (!rdy) begin
          w++;
          checks++;
          if (m_hresp !== sb[0].err) begin
            failures++;
            $display("FAIL stall_hresp @%h: got %b want %b", sb[0].addr, m_hresp, sb[0].err);
          end
        end else begin
          ep = sb.pop_front();
          checks++;
          if (w !== ep.waits) begin
            failures++;
            $display("FAIL wait_cycles @%h: got %0d want %0d", ep.addr, w, ep.waits);
          end
          checks++;
          if (m_hresp !== ep.err) begin
            failures++;
            $display("FAIL hresp @%h: got %b want %b", ep.addr, m_hresp, ep.err);
          end
          if (ep.chk_data) begin
            checks++;
            if (m_hrdata !== ep.data) begin
              failures++;
              $display("FAIL hrdata @%h: got %h want %h", ep.addr, m_hrdata, ep.data);
            end
          end
        end
      end
      @(posedge hclk); #1;
      if (rdy) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL beat_timeout @%h: got no hready want hready within 40 cycles", a);
      sb.delete();
      have_pend = 0;
    end else begin
      sb.push_back(e);
      have_pend = 1;
      pend_wdata = wd;
    end
  endtask

  task automatic drain(input int d);
    exp_t ep;
    beat(d, 1'b1, IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge hclk);
    if (sb.size() > 0) begin
      ep = sb.pop_front();
      checks++;
      if (m_hready !== 1'b1 || m_hresp !== ep.err) begin
        failures++;
        $display("FAIL idle_phase: got ready=%b resp=%b want ready=1 resp=0", m_hready, m_hresp);
      end
    end
    @(posedge hclk); #1;
    have_pend = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    checks += 3;
    if ({bus0.hreadyout, bus1.hreadyout, bus2.hreadyout} !== 3'b111) begin
      failures++;
      $display("FAIL reset_hreadyout: got %b want 111", {bus0.hreadyout, bus1.hreadyout, bus2.hreadyout});
    end
    if ({bus0.hresp, bus1.hresp, bus2.hresp} !== 3'b000) begin
      failures++;
      $display("FAIL reset_hresp: got %b want 000", {bus0.hresp, bus1.hresp, bus2.hresp});
    end
    if ((bus0.hrdata | bus1.hrdata | bus2.hrdata) !== 32'h0) begin
      failures++;
      $display("FAIL reset_hrdata: got %h want 00000000", bus0.hrdata | bus1.hrdata | bus2.hrdata);
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_back_to_back();
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    drain(0);
  endtask

  task automatic test_wait_states();
    beat(1, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h0, 32'hA5A50F0F);
    beat(1, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h0, 32'h0);
    drain(1);
  endtask

  task automatic test_byte_lanes();
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h10, 32'h11223344);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd0, 32'h13, 32'hAA000000);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h14, 32'h55667788);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd1, 32'h16, 32'hBEEF0000);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd0, 32'h14, 32'h000000CC);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h14, 32'h0);
    drain(0);
  endtask

  task automatic test_errors();
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h0, 32'h01020304);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd1, 32'h1, 32'hFFFFFFFF);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h1000, 32'hFFFFFFFF);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd3, 32'h0, 32'hFFFFFFFF);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h2, 32'hFFFFFFFF);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h1000, 32'h0);
    beat(0, 1'b1, NONSEQ, 1'b1, 3'd2, 32'hFFC, 32'h0BADF00D);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'hFFC, 32'h0);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h0, 32'h0);
    drain(0);
  endtask

  task automatic test_burst();
    hburst = 3'b011;
    beat(2, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h20, 32'h20202020);
    beat(2, 1'b1, SEQ,    1'b1, 3'd2, 32'h24, 32'h24242424);
    beat(2, 1'b1, BUSY,   1'b1, 3'd2, 32'h28, 32'h0);
    beat(2, 1'b1, SEQ,    1'b1, 3'd2, 32'h28, 32'h28282828);
    beat(2, 1'b1, SEQ,    1'b1, 3'd2, 32'h2C, 32'h2C2C2C2C);
    for (int i = 0; i < 4; i++)
      beat(2, 1'b1, (i == 0) ? NONSEQ : SEQ, 1'b0, 3'd2, 32'h20 + 32'(4 * i), 32'h0);
    drain(2);
    hburst = 3'b000;
  endtask

  task automatic test_hsel_low();
    beat(0, 1'b0, NONSEQ, 1'b1, 3'd2, 32'h10, 32'h0);
    beat(0, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    drain(0);
  endtask

  task automatic test_reset_mid();
    beat(1, 1'b1, NONSEQ, 1'b1, 3'd2, 32'h40, 32'h12345678);
    drain(1);
    cur_dut = 1; hsel_g = 1'b1; htrans = NONSEQ; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge hclk); #1;
    htrans = IDLE; hwdata = 32'hCAFEF00D;
    @(negedge hclk);
    checks++;
    if (bus1.hreadyout !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_hreadyout: got %b want 0", bus1.hreadyout);
    end
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    checks += 2;
    if (bus1.hreadyout !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_hreadyout: got %b want 1", bus1.hreadyout);
    end
    if (bus1.hresp !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hresp: got %b want 0", bus1.hresp);
    end
    @(posedge hclk); #1;
    beat(1, 1'b1, NONSEQ, 1'b0, 3'd2, 32'h40, 32'h0);
    drain(1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_burst();
    test_hsel_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
